// File: rtl/piezo_alarm_gen.sv
// Parametrised N-channel piezo alarm sequencer.
// Picks the highest-index active request. It plays that channel's square-wave tone, gated by
// an on/off cadence, on a differential piezo pair. A saturating hold timer tracks how long
// alarms have been continuously active.
// Optional build macro: PIEZO_MUTE_EN adds a 'mute' input that silences both legs while the
// sequencer keeps running underneath.

`timescale 1ns/1ps

module piezo_alarm_gen #(
  parameter int unsigned NUM_ALM   = 3,
  parameter int unsigned TONE_W    = 16,
  parameter int unsigned CAD_W     = 12,
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned TMR_TICKS = 1500,
  parameter bit          FAST_SIM  = 1'b0,
  localparam int unsigned IdW      = (NUM_ALM > 1) ? $clog2(NUM_ALM) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_ALM-1:0]        alarm_req,
  input  logic [NUM_ALM*TONE_W-1:0] tone_half,
  input  logic [NUM_ALM*CAD_W-1:0]  on_ticks,
  input  logic [NUM_ALM*CAD_W-1:0]  off_ticks,
  input  logic                      tmr_clr,
`ifdef PIEZO_MUTE_EN
  input  logic                      mute,
`endif
  output logic                      piezo,
  output logic                      piezo_n,
  output logic [IdW-1:0]            active_id,
  output logic                      tmr_full
);

  // Simulation shortcut shrinks both the tick divider and the hold threshold.
  localparam int unsigned Div = FAST_SIM ? 32'd16 : TICK_DIV;
  localparam int unsigned Tmr = FAST_SIM ? 32'd64 : TMR_TICKS;
  localparam int unsigned PW  = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned HW  = $clog2(Tmr + 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOn   = 2'd1,
    StOff  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IdW-1:0]    sel_q, sel_d;
  logic [CAD_W-1:0]  cad_q, cad_d;
  logic [TONE_W-1:0] tone_q, tone_d;
  logic              phase_q, phase_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [HW-1:0]     hold_q, hold_d;

  logic              piezo_d, piezo_n_d, tmr_full_d;
  logic [IdW-1:0]    active_id_d;

  logic              tick;
  logic              any;
  logic [IdW-1:0]    sel;

  // Per-channel configuration fields unpacked for indexed access.
  logic [TONE_W-1:0] tone_arr [NUM_ALM];
  logic [CAD_W-1:0]  on_arr   [NUM_ALM];
  logic [CAD_W-1:0]  off_arr  [NUM_ALM];

  for (genvar g = 0; g < NUM_ALM; g++) begin : g_unpack
    assign tone_arr[g] = tone_half[g*TONE_W +: TONE_W];
    assign on_arr[g]   = on_ticks[g*CAD_W +: CAD_W];
    assign off_arr[g]  = off_ticks[g*CAD_W +: CAD_W];
  end

  // Values of the newly selected channel (used on start/restart).
  logic [TONE_W-1:0] new_tone;
  logic [CAD_W-1:0]  new_on;
  // Values of the latched channel (used on cadence reloads).
  logic [TONE_W-1:0] cur_tone;
  logic [CAD_W-1:0]  cur_on;
  logic [CAD_W-1:0]  cur_off;

  assign new_tone = tone_arr[sel];
  assign new_on   = on_arr[sel];
  assign cur_tone = tone_arr[sel_q];
  assign cur_on   = on_arr[sel_q];
  assign cur_off  = off_arr[sel_q];

  assign any  = |alarm_req;
  assign tick = (presc_q == PW'(Div - 1));

  // Priority encoder: the highest set request bit wins.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_ALM; i++) begin
      if (alarm_req[i]) begin
        sel = IdW'(i);
      end
    end
  end

  // Free-running cadence prescaler, cleared only by reset.
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  // Sequencer next state: channel select, tone generator and cadence counter.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cad_d   = cad_q;
    tone_d  = tone_q;
    phase_d = phase_q;

    if (!any) begin
      state_d = StIdle;
      sel_d   = '0;
      cad_d   = '0;
      tone_d  = '0;
      phase_d = 1'b0;
    end else if ((state_q == StIdle) || (sel != sel_q)) begin
      // Fresh start or priority change: restart on the winning channel.
      sel_d   = sel;
      tone_d  = new_tone;
      phase_d = 1'b1;
      if (new_on == '0) begin
        // Silent channel: park in OFF until its ON length becomes non-zero.
        state_d = StOff;
        cad_d   = '0;
      end else begin
        state_d = StOn;
        cad_d   = new_on;
      end
    end else begin
      unique case (state_q)
        StOn: begin
          if (tone_q == '0) begin
            tone_d  = cur_tone;
            phase_d = ~phase_q;
          end else begin
            tone_d = tone_q - 1'b1;
          end
          if (tick) begin
            if (cad_q <= CAD_W'(1)) begin
              if (cur_off != '0) begin
                state_d = StOff;
                cad_d   = cur_off;
              end else if (cur_on != '0) begin
                // Zero OFF length: continuous tone, tone phase runs on uninterrupted.
                cad_d = cur_on;
              end else begin
                state_d = StOff;
                cad_d   = '0;
              end
            end else begin
              cad_d = cad_q - 1'b1;
            end
          end
        end
        StOff: begin
          if (tick) begin
            if (cad_q <= CAD_W'(1)) begin
              if (cur_on != '0) begin
                state_d = StOn;
                cad_d   = cur_on;
                tone_d  = cur_tone;
                phase_d = 1'b1;
              end else begin
                cad_d = '0;
              end
            end else begin
              cad_d = cad_q - 1'b1;
            end
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Hold timer: counts ticks of continuous activity; a clear beats a coincident tick.
  always_comb begin
    hold_d = hold_q;
    if (!any || tmr_clr) begin
      hold_d = '0;
    end else if (tick && (hold_q != HW'(Tmr))) begin
      hold_d = hold_q + 1'b1;
    end
    tmr_full_d = (hold_d == HW'(Tmr));
  end

  // Output decode from next state so every output is a plain register.
  always_comb begin
    piezo_d   = 1'b0;
    piezo_n_d = 1'b0;
    unique case (state_d)
      StOn: begin
        piezo_d   = phase_d;
        piezo_n_d = ~phase_d;
      end
      StOff: begin
        piezo_n_d = 1'b1;
      end
      default: begin
        piezo_d   = 1'b0;
        piezo_n_d = 1'b0;
      end
    endcase
`ifdef PIEZO_MUTE_EN
    if (mute) begin
      piezo_d   = 1'b0;
      piezo_n_d = 1'b0;
    end
`endif
    active_id_d = (state_d == StIdle) ? '0 : sel_d;
  end

  // Sequencer, prescaler and hold-timer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= '0;
      cad_q   <= '0;
      tone_q  <= '0;
      phase_q <= 1'b0;
      presc_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cad_q   <= cad_d;
      tone_q  <= tone_d;
      phase_q <= phase_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      piezo     <= 1'b0;
      piezo_n   <= 1'b0;
      active_id <= '0;
      tmr_full  <= 1'b0;
    end else begin
      piezo     <= piezo_d;
      piezo_n   <= piezo_n_d;
      active_id <= active_id_d;
      tmr_full  <= tmr_full_d;
    end
  end

endmodule

// File: tb/tb_piezo_alarm_gen.sv
// Directed self-checking bench for piezo_alarm_gen (NUM_ALM=3, FAST_SIM=1, tick every 16 clk).

`timescale 1ns/1ps

module tb_piezo_alarm_gen;

  localparam int unsigned NumAlm = 3;
  localparam int unsigned ToneW  = 16;
  localparam int unsigned CadW   = 12;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NumAlm-1:0]        alarm_req = '0;
  logic [NumAlm*ToneW-1:0]  tone_half = '0;
  logic [NumAlm*CadW-1:0]   on_ticks = '0;
  logic [NumAlm*CadW-1:0]   off_ticks = '0;
  logic                     tmr_clr = 1'b0;
`ifdef PIEZO_MUTE_EN
  logic                     mute = 1'b0;
`endif
  logic                     piezo;
  logic                     piezo_n;
  logic [1:0]               active_id;
  logic                     tmr_full;

  int unsigned cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;

  piezo_alarm_gen #(
    .NUM_ALM  (NumAlm),
    .TONE_W   (ToneW),
    .CAD_W    (CadW),
    .TICK_DIV (50000),
    .TMR_TICKS(1500),
    .FAST_SIM (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alarm_req(alarm_req),
    .tone_half(tone_half),
    .on_ticks (on_ticks),
    .off_ticks(off_ticks),
    .tmr_clr  (tmr_clr),
`ifdef PIEZO_MUTE_EN
    .mute     (mute),
`endif
    .piezo    (piezo),
    .piezo_n  (piezo_n),
    .active_id(active_id),
    .tmr_full (tmr_full)
  );

  always #5 clk = ~clk;

  // Edge count since reset release; mirrors the prescaler phase (tick edge when cyc%16==15).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Leave the bench at a negedge whose following posedge is a cadence tick.
  task automatic align_tick();
    for (int i = 0; i < 17; i++) begin
      if ((cyc % 16) == 15) return;
      @(negedge clk);
    end
    n_total++;
    n_bad++;
    $display("FAIL align_tick cyc=%0d never reached phase 15", cyc);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    alarm_req = 3'b111;
    repeat (3) @(negedge clk);
    n_total++;
    if ({piezo, piezo_n, active_id, tmr_full} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_hold got=%b exp=00000", {piezo, piezo_n, active_id, tmr_full});
    end
    alarm_req = '0;
    rst_n     = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if ({piezo, piezo_n, active_id, tmr_full} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_idle got=%b exp=00000", {piezo, piezo_n, active_id, tmr_full});
    end
  endtask

  // h0=3 (period 8), on0=4 ticks (64 clk), off0=2 ticks (32 clk).
  task automatic test_cadence();
    logic ep, en;
    int   kk;
    tone_half[0*ToneW +: ToneW] = 16'd3;
    on_ticks[0*CadW +: CadW]    = 12'd4;
    off_ticks[0*CadW +: CadW]   = 12'd2;
    align_tick();
    n_total++;
    if ({piezo, piezo_n} !== 2'b00) begin
      n_bad++;
      $display("FAIL cad_pre_idle got=%b exp=00", {piezo, piezo_n});
    end
    alarm_req = 3'b001;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      kk = k % 96;
      ep = (kk < 64) ? (((kk / 4) % 2) == 0) : 1'b0;
      en = (kk < 64) ? ~ep : 1'b1;
      n_total++;
      if ({piezo, piezo_n} !== {ep, en}) begin
        n_bad++;
        $display("FAIL cadence k=%0d got=%b exp=%b", k, {piezo, piezo_n}, {ep, en});
      end
    end
    n_total++;
    if (active_id !== 2'd0) begin
      n_bad++;
      $display("FAIL cad_active_id got=%0d exp=0", active_id);
    end
    alarm_req = '0;
    @(negedge clk);
    n_total++;
    if ({piezo, piezo_n, active_id} !== 4'b0) begin
      n_bad++;
      $display("FAIL cad_drop got=%b exp=0000", {piezo, piezo_n, active_id});
    end
  endtask

  // Channel 0 into OFF, then channel 2 takes over (h2=1 -> period 4), then drop to idle.
  task automatic test_priority();
    logic ep;
    tone_half[2*ToneW +: ToneW] = 16'd1;
    on_ticks[2*CadW +: CadW]    = 12'd5;
    off_ticks[2*CadW +: CadW]   = 12'd3;
    align_tick();
    alarm_req = 3'b001;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (k == 64) begin
        n_total++;
        if ({piezo, piezo_n, active_id} !== 4'b0100) begin
          n_bad++;
          $display("FAIL prio_off got=%b exp=0100", {piezo, piezo_n, active_id});
        end
      end
    end
    alarm_req = 3'b101;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      ep = (((j / 2) % 2) == 0);
      n_total++;
      if ({piezo, piezo_n, active_id} !== {ep, ~ep, 2'd2}) begin
        n_bad++;
        $display("FAIL prio_ch2 j=%0d got=%b exp=%b", j, {piezo, piezo_n, active_id},
                 {ep, ~ep, 2'd2});
      end
    end
    alarm_req = '0;
    @(negedge clk);
    n_total++;
    if ({piezo, piezo_n, active_id} !== 4'b0) begin
      n_bad++;
      $display("FAIL prio_idle got=%b exp=0000", {piezo, piezo_n, active_id});
    end
  endtask

  // off1=0: cadence reloads ON and the 6-clk square wave never breaks.
  task automatic test_continuous();
    logic ep;
    tone_half[1*ToneW +: ToneW] = 16'd2;
    on_ticks[1*CadW +: CadW]    = 12'd2;
    off_ticks[1*CadW +: CadW]   = 12'd0;
    align_tick();
    alarm_req = 3'b010;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      ep = (((k / 3) % 2) == 0);
      n_total++;
      if ({piezo, piezo_n, active_id} !== {ep, ~ep, 2'd1}) begin
        n_bad++;
        $display("FAIL continuous k=%0d got=%b exp=%b", k, {piezo, piezo_n, active_id},
                 {ep, ~ep, 2'd1});
      end
    end
    alarm_req = '0;
    @(negedge clk);
  endtask

  // on1=0: channel is silent and parks in OFF while requested.
  task automatic test_silent();
    on_ticks[1*CadW +: CadW] = 12'd0;
    alarm_req = 3'b010;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      n_total++;
      if ({piezo, piezo_n, active_id} !== 4'b0101) begin
        n_bad++;
        $display("FAIL silent k=%0d got=%b exp=0101", k, {piezo, piezo_n, active_id});
      end
    end
    alarm_req = '0;
    @(negedge clk);
    n_total++;
    if ({piezo, piezo_n, active_id} !== 4'b0) begin
      n_bad++;
      $display("FAIL silent_idle got=%b exp=0000", {piezo, piezo_n, active_id});
    end
  endtask

  // Hold timer: the request's first edge is a tick, so the 64th tick lands at edge 1008.
  task automatic test_hold();
    align_tick();
    alarm_req = 3'b001;
    for (int k = 0; k <= 2150; k++) begin
      @(negedge clk);
      if (k == 1007 || k == 1120 || k == 2143) begin
        n_total++;
        if (tmr_full !== 1'b0) begin
          n_bad++;
          $display("FAIL hold_low k=%0d got=%b exp=0", k, tmr_full);
        end
      end
      if (k == 1008 || k == 1100 || k == 2144) begin
        n_total++;
        if (tmr_full !== 1'b1) begin
          n_bad++;
          $display("FAIL hold_high k=%0d got=%b exp=1", k, tmr_full);
        end
      end
      // Clear lands on the tick edge at k=1120.
      if (k == 1119) tmr_clr = 1'b1;
      if (k == 1120) tmr_clr = 1'b0;
    end
    alarm_req = '0;
    @(negedge clk);
    n_total++;
    if (tmr_full !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_drop got=%b exp=0", tmr_full);
    end
  endtask

  task automatic test_reset_mid_on();
    tone_half[0*ToneW +: ToneW] = 16'd3;
    on_ticks[0*CadW +: CadW]    = 12'd4;
    alarm_req = 3'b001;
    @(negedge clk);
    n_total++;
    if ({piezo, piezo_n, active_id} !== 4'b1000) begin
      n_bad++;
      $display("FAIL rst_pre_on got=%b exp=1000", {piezo, piezo_n, active_id});
    end
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({piezo, piezo_n, active_id, tmr_full} !== 5'b0) begin
      n_bad++;
      $display("FAIL rst_async got=%b exp=00000", {piezo, piezo_n, active_id, tmr_full});
    end
    alarm_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if ({piezo, piezo_n, active_id, tmr_full} !== 5'b0) begin
      n_bad++;
      $display("FAIL rst_release got=%b exp=00000", {piezo, piezo_n, active_id, tmr_full});
    end
    alarm_req = 3'b001;
    @(negedge clk);
    n_total++;
    if ({piezo, piezo_n} !== 2'b10) begin
      n_bad++;
      $display("FAIL rst_latency got=%b exp=10", {piezo, piezo_n});
    end
    alarm_req = '0;
    @(negedge clk);
  endtask

`ifdef PIEZO_MUTE_EN
  task automatic test_mute();
    logic ep, en;
    align_tick();
    alarm_req = 3'b001;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (k >= 3 && k <= 30) begin
        ep = 1'b0;
        en = 1'b0;
      end else begin
        ep = (((k / 4) % 2) == 0);
        en = ~ep;
      end
      n_total++;
      if ({piezo, piezo_n} !== {ep, en}) begin
        n_bad++;
        $display("FAIL mute k=%0d got=%b exp=%b", k, {piezo, piezo_n}, {ep, en});
      end
      if (k == 2)  mute = 1'b1;
      if (k == 30) mute = 1'b0;
    end
    alarm_req = '0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_cadence();
    test_priority();
    test_continuous();
    test_silent();
    test_hold();
    test_reset_mid_on();
`ifdef PIEZO_MUTE_EN
    test_mute();
`endif
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
